// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, codeword type and scrubber state encoding
package hamming_pkg;
    localparam int DATA_W = 8;
    localparam int CODE_W = 12;
    localparam int SYN_W  = 4;

    typedef logic [CODE_W-1:0] codeword_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
        S_WR_REQ,
        S_NEXT,
        S_DONE
    } scrub_state_t;
endpackage

// File: rtl/hamming_code.sv
// hamming_code: combinational Hamming(12,8) encoder, parity at positions 1,2,4,8
module hamming_code
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output codeword_t         code
);
    logic p1, p2, p4, p8;

    assign p1 = ^{data[0], data[1], data[3], data[4], data[6]};
    assign p2 = ^{data[0], data[2], data[3], data[5], data[6]};
    assign p4 = ^{data[1], data[2], data[3], data[7]};
    assign p8 = ^data[7:4];

    // bit i of the codeword holds Hamming position i+1
    assign code = {data[7:4], p8, data[3:1], p4, data[0], p2, p1};
endmodule

// File: rtl/hamming_decode.sv
// hamming_decode: combinational Hamming(12,8) SEC decoder
module hamming_decode
    import hamming_pkg::*;
(
    input  codeword_t         code,
    output logic [DATA_W-1:0] data,
    output logic [SYN_W-1:0]  syndrome
);
    codeword_t fixed;

    assign syndrome[0] = ^{code[0], code[2], code[4], code[6], code[8], code[10]};
    assign syndrome[1] = ^{code[1], code[2], code[5], code[6], code[9], code[10]};
    assign syndrome[2] = ^{code[3], code[4], code[5], code[6], code[11]};
    assign syndrome[3] = ^code[11:7];

    // syndromes 13..15 name no real position, so nothing is flipped for them
    assign fixed = (syndrome != '0 && syndrome <= SYN_W'(CODE_W))
                 ? code ^ (codeword_t'(1) << (syndrome - SYN_W'(1)))
                 : code;

    assign data = {fixed[11:8], fixed[6:4], fixed[2]};
endmodule

// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl: background scrubber that reads, checks and rewrites every memory word
module hamming_scrub_ctrl
    import hamming_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CODE_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [CODE_W-1:0] mem_rdata
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    scrub_state_t      state, state_nx;
    logic [ADDR_W-1:0] addr;
    codeword_t         word_q, wdata_q, enc_word;
    logic [DATA_W-1:0] dec_data;
    logic [SYN_W-1:0]  syndrome;
    logic              abort_q;
    logic              stop;

    hamming_decode u_dec (
        .code     (word_q),
        .data     (dec_data),
        .syndrome (syndrome)
    );

    hamming_code u_enc (
        .data (dec_data),
        .code (enc_word)
    );

    // an abort seen anywhere inside a word is remembered and acted on at the word boundary
    assign stop = abort || abort_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    state_nx = start ? S_RD_REQ : S_IDLE;
            S_RD_REQ:  state_nx = mem_gnt ? S_RD_WAIT : S_RD_REQ;
            S_RD_WAIT: state_nx = mem_rvalid ? S_CHECK : S_RD_WAIT;
            S_CHECK:   state_nx = (syndrome != '0) ? S_WR_REQ : S_NEXT;
            S_WR_REQ:  state_nx = mem_gnt ? S_NEXT : S_WR_REQ;
            S_NEXT:    state_nx = (stop || addr == LAST) ? S_DONE : S_RD_REQ;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // outputs decoded from state; request fields come straight from held registers
    always_comb begin
        busy      = state != S_IDLE;
        done      = state == S_DONE;
        mem_req   = state == S_RD_REQ || state == S_WR_REQ;
        mem_we    = state == S_WR_REQ;
        mem_addr  = addr;
        mem_wdata = wdata_q;
    end

    // address, counters, captured read word and corrected write data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= '0;
            err_count     <= '0;
            last_err_addr <= '0;
            aborted       <= 1'b0;
            abort_q       <= 1'b0;
            word_q        <= '0;
            wdata_q       <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                addr      <= '0;
                err_count <= '0;
                aborted   <= 1'b0;
                abort_q   <= 1'b0;
            end else if (state != S_IDLE && abort) begin
                abort_q <= 1'b1;
            end
            if (state == S_RD_WAIT && mem_rvalid)
                word_q <= mem_rdata;
            if (state == S_CHECK && syndrome != '0) begin
                wdata_q       <= enc_word;
                last_err_addr <= addr;
                if (!(&err_count))
                    err_count <= err_count + 1'b1;
            end
            if (state == S_NEXT) begin
                if (stop)
                    aborted <= 1'b1;
                else if (addr != LAST)
                    addr <= addr + 1'b1;
            end
        end
    end
endmodule
